// File: rtl/dcache_responder_if.sv
// Core-side EX/MEM request bus and backing-memory req/ack bus of the data cache.
interface dcache_responder_if;
    logic [31:0] exmem_alu_output;
    logic        exmem_memread;
    logic        exmem_memwrite;
    logic [31:0] exmem_write_data;
    logic [31:0] read_data_from_dcache;
    logic        dcache_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  exmem_alu_output, exmem_memread, exmem_memwrite, exmem_write_data,
        input  mem_rdata, mem_ack,
        output read_data_from_dcache, dcache_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output exmem_alu_output, exmem_memread, exmem_memwrite, exmem_write_data,
        output mem_rdata, mem_ack,
        input  read_data_from_dcache, dcache_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with a stall to the core
// and a single-outstanding req/ack port to backing memory.
module dcache_responder #(
    parameter int unsigned INDEX_BITS  = 4,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input logic             clk,
    input logic             reset,
    dcache_responder_if.slave bus
);
    localparam int unsigned Lines   = 1 << INDEX_BITS;
    localparam int unsigned TagBits = 30 - INDEX_BITS;

    if (MEM_TIMEOUT != 0) begin : g_timeout_unsupported
        $error("dcache_responder: MEM_TIMEOUT other than 0 is not implemented");
    end

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StWdone} state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [Lines-1:0]        r_valid;
    logic [TagBits-1:0]      r_tag_ram  [Lines];
    logic [31:0]             r_data_ram [Lines];
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [31:0]             r_mem_addr;
    logic [31:0]             r_mem_wdata;

    logic [INDEX_BITS-1:0]   w_index;
    logic [TagBits-1:0]      w_tag;
    logic [INDEX_BITS-1:0]   w_fill_index;
    logic [TagBits-1:0]      w_fill_tag;
    logic                    w_hit;
    logic                    w_stall;
    logic [31:0]             w_rdata;
    logic                    w_issue_rd;
    logic                    w_issue_wr;
    logic                    w_done;
    logic                    w_unused;

    assign w_index      = bus.exmem_alu_output[INDEX_BITS+1:2];
    assign w_tag        = bus.exmem_alu_output[31:INDEX_BITS+2];
    // The fill target comes from the registered request, not the live core address.
    assign w_fill_index = r_mem_addr[INDEX_BITS+1:2];
    assign w_fill_tag   = r_mem_addr[31:INDEX_BITS+2];
    assign w_hit        = r_valid[w_index] && (r_tag_ram[w_index] == w_tag);
    assign w_done       = bus.mem_ack && ((r_state == StFill) || (r_state == StWrite));
    assign w_unused     = ^bus.exmem_alu_output[1:0];

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_rdata      = '0;
        w_issue_rd   = 1'b0;
        w_issue_wr   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.exmem_memwrite) begin
                    w_stall      = 1'b1;
                    w_issue_wr   = 1'b1;
                    w_state_next = StWrite;
                end else if (bus.exmem_memread) begin
                    if (w_hit) begin
                        w_rdata = r_data_ram[w_index];
                    end else begin
                        w_stall      = 1'b1;
                        w_issue_rd   = 1'b1;
                        w_state_next = StFill;
                    end
                end
            end
            StFill: begin
                w_stall = 1'b1;
                if (bus.mem_ack) w_state_next = StIdle;
            end
            StWrite: begin
                w_stall = 1'b1;
                if (bus.mem_ack) w_state_next = StWdone;
            end
            StWdone: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Reset forces the core-facing outputs low even while a request is still presented.
    assign bus.dcache_stall          = w_stall & reset;
    assign bus.read_data_from_dcache = w_rdata & {32{reset}};
    assign bus.mem_req               = r_mem_req;
    assign bus.mem_we                = r_mem_we;
    assign bus.mem_addr              = r_mem_addr;
    assign bus.mem_wdata             = r_mem_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_valid     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_issue_rd || w_issue_wr) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= w_issue_wr;
                r_mem_addr <= {bus.exmem_alu_output[31:2], 2'b00};
                if (w_issue_wr) r_mem_wdata <= bus.exmem_write_data;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end
            if (w_done && (r_state == StFill)) r_valid[w_fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_done && (r_state == StFill)) begin
            r_data_ram[w_fill_index] <= bus.mem_rdata;
            r_tag_ram[w_fill_index]  <= w_fill_tag;
        end else if (w_issue_wr && w_hit) begin
            r_data_ram[w_index] <= bus.exmem_write_data;
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder; backing-memory acks are driven by hand per step.
module tb_dcache_responder;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    dcache_responder_if bus ();

    dcache_responder #(
        .INDEX_BITS  (4),
        .MEM_TIMEOUT (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd);
        bus.exmem_memread    = rd;
        bus.exmem_memwrite   = wr;
        bus.exmem_alu_output = addr;
        bus.exmem_write_data = wd;
        #1;
    endtask

    // Pulse mem_ack for the current cycle, then drop it after the edge.
    task automatic ack(input logic [31:0] rdata);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        #1;
        tick();
        bus.mem_ack = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("rst_stall", {31'b0, bus.dcache_stall}, 32'h0);
        check("rst_req", {31'b0, bus.mem_req}, 32'h0);
        check("rst_we", {31'b0, bus.mem_we}, 32'h0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_rdata", bus.read_data_from_dcache, 32'h0);
        reset = 1'b1;
        #1;

        // First read after reset must miss
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        check("rst_miss_stall", {31'b0, bus.dcache_stall}, 32'h1);
        check("rst_miss_noreq", {31'b0, bus.mem_req}, 32'h0);
        tick();
        check("rst_miss_req", {31'b0, bus.mem_req}, 32'h1);
        check("rst_miss_addr", bus.mem_addr, 32'h100);
        check("rst_miss_we", {31'b0, bus.mem_we}, 32'h0);
        ack(32'hA5A5_A5A5);
        check("fill100_stall", {31'b0, bus.dcache_stall}, 32'h0);
        check("fill100_data", bus.read_data_from_dcache, 32'hA5A5_A5A5);

        // Read miss with L=3: stall for 4 cycles, hit on the 5th
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        check("m40_c0_stall", {31'b0, bus.dcache_stall}, 32'h1);
        tick();
        check("m40_c1_req", {31'b0, bus.mem_req}, 32'h1);
        check("m40_c1_addr", bus.mem_addr, 32'h40);
        check("m40_c1_stall", {31'b0, bus.dcache_stall}, 32'h1);
        tick();
        check("m40_c2_stall", {31'b0, bus.dcache_stall}, 32'h1);
        tick();
        check("m40_c3_stall", {31'b0, bus.dcache_stall}, 32'h1);
        ack(32'hDEAD_BEEF);
        check("m40_c4_stall", {31'b0, bus.dcache_stall}, 32'h0);
        check("m40_c4_data", bus.read_data_from_dcache, 32'hDEAD_BEEF);
        check("m40_c4_req", {31'b0, bus.mem_req}, 32'h0);
        tick();
        check("h40_data", bus.read_data_from_dcache, 32'hDEAD_BEEF);
        check("h40_noreq", {31'b0, bus.mem_req}, 32'h0);

        // Write hit to 0x42 (word 0x40), L=3
        drive(1'b0, 1'b1, 32'h42, 32'h1234_5678);
        check("wh_c0_stall", {31'b0, bus.dcache_stall}, 32'h1);
        check("wh_c0_rdata", bus.read_data_from_dcache, 32'h0);
        tick();
        check("wh_req", {31'b0, bus.mem_req}, 32'h1);
        check("wh_we", {31'b0, bus.mem_we}, 32'h1);
        check("wh_addr", bus.mem_addr, 32'h40);
        check("wh_wdata", bus.mem_wdata, 32'h1234_5678);
        tick();
        check("wh_c2_stall", {31'b0, bus.dcache_stall}, 32'h1);
        tick();
        check("wh_c3_stall", {31'b0, bus.dcache_stall}, 32'h1);
        ack(32'h0);
        check("wdone_stall", {31'b0, bus.dcache_stall}, 32'h0);
        check("wdone_req", {31'b0, bus.mem_req}, 32'h0);
        check("wdone_we", {31'b0, bus.mem_we}, 32'h0);
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        check("wdone_rd_ignored", bus.read_data_from_dcache, 32'h0);
        tick();
        check("wh_readback", bus.read_data_from_dcache, 32'h1234_5678);
        check("wh_readback_stall", {31'b0, bus.dcache_stall}, 32'h0);
        tick();
        check("wh_readback_noreq", {31'b0, bus.mem_req}, 32'h0);

        // Write miss to 0x1000 leaves the cache untouched
        drive(1'b0, 1'b1, 32'h1000, 32'h55);
        check("wm_stall", {31'b0, bus.dcache_stall}, 32'h1);
        tick();
        check("wm_req", {31'b0, bus.mem_req}, 32'h1);
        check("wm_we", {31'b0, bus.mem_we}, 32'h1);
        check("wm_addr", bus.mem_addr, 32'h1000);
        check("wm_wdata", bus.mem_wdata, 32'h55);
        ack(32'h0);
        check("wm_wdone_stall", {31'b0, bus.dcache_stall}, 32'h0);
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        check("wm_40_still_hit", bus.read_data_from_dcache, 32'h1234_5678);
        drive(1'b1, 1'b0, 32'h1000, 32'h0);
        check("wm_1000_miss", {31'b0, bus.dcache_stall}, 32'h1);
        tick();
        check("f1000_addr", bus.mem_addr, 32'h1000);
        check("f1000_we", {31'b0, bus.mem_we}, 32'h0);
        ack(32'h77);
        check("f1000_data", bus.read_data_from_dcache, 32'h77);

        // Conflict: 0x1000 evicted 0x40 from index 0
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        check("evict_40_miss", {31'b0, bus.dcache_stall}, 32'h1);
        tick();
        check("evict_40_addr", bus.mem_addr, 32'h40);
        ack(32'hCAFE_F00D);
        check("evict_40_data", bus.read_data_from_dcache, 32'hCAFE_F00D);

        // Read and write together behaves as a write
        drive(1'b1, 1'b1, 32'h80, 32'h99);
        check("rw_stall", {31'b0, bus.dcache_stall}, 32'h1);
        check("rw_rdata", bus.read_data_from_dcache, 32'h0);
        tick();
        check("rw_we", {31'b0, bus.mem_we}, 32'h1);
        check("rw_wdata", bus.mem_wdata, 32'h99);
        ack(32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Reset two cycles into a fill, then a stray ack
        drive(1'b1, 1'b0, 32'h200, 32'h0);
        check("mr_stall", {31'b0, bus.dcache_stall}, 32'h1);
        tick();
        check("mr_req", {31'b0, bus.mem_req}, 32'h1);
        tick();
        reset = 1'b0;
        #1;
        check("mr_rst_req", {31'b0, bus.mem_req}, 32'h0);
        check("mr_rst_stall", {31'b0, bus.dcache_stall}, 32'h0);
        check("mr_rst_addr", bus.mem_addr, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        tick();
        ack(32'h0BAD_0BAD);
        check("stray_ack_noreq", {31'b0, bus.mem_req}, 32'h0);
        drive(1'b1, 1'b0, 32'h200, 32'h0);
        check("stray_no_fill", {31'b0, bus.dcache_stall}, 32'h1);
        check("stray_no_fill_rd", bus.read_data_from_dcache, 32'h0);
        tick();
        check("mr_refill_addr", bus.mem_addr, 32'h200);
        ack(32'h2222_2222);
        check("mr_refill_data", bus.read_data_from_dcache, 32'h2222_2222);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
